// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard scheduler for the 5-stage pipe (IF, ID, DEC_ALU/EX, MEM, WB).
// It watches the instruction sitting in ID and keeps a three-entry record of
// the destinations still in flight (EX, MEM, WB). From these it drives the
// stall, flush and bubble controls of the pipeline registers. It also runs
// the data-cache req/ready handshake for whatever instruction is in MEM.
//
// Parameters
//   FWD_EN       1: forwarding exists, so only a load in EX causes a stall.
//                0: full interlock on any RAW match against EX, MEM or WB.
//   MEM_WAIT_MAX number of cache-wait cycles after which mem_timeout latches.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   id_valid            instruction in ID is valid
//   id_opcode           inst[6:0] of the ID instruction
//   id_readAddr1/2      rs1 / rs2 of the ID instruction
//   id_writeAddr        rd of the ID instruction
//   id_regWriteEnable   ID instruction writes the register file
//   id_dataCacheControl NOP / Read / Write for the ID instruction
//   ex_branchTaken      redirect resolved in EX this cycle
//   dc_ready            data cache finishes the current access
//   dc_req              cache request for the instruction in MEM
//   pc_stall            hold PC
//   ifid_stall          hold IF/ID
//   ifid_flush          clear IF/ID to NOP
//   idex_bubble         load NOP into ID/EX
//   front_freeze        hold ID/EX and EX/MEM during a cache wait
//   memwb_bubble        load NOP into MEM/WB during a cache wait
//   mem_timeout         sticky: a cache wait ran for MEM_WAIT_MAX cycles

`ifndef DataCacheControlBus
`define DataCacheControlBus 1:0
`endif
`ifndef DataCacheNOP
`define DataCacheNOP 2'b00
`endif
`ifndef DataCacheRead
`define DataCacheRead 2'b01
`endif
`ifndef DataCacheWrite
`define DataCacheWrite 2'b10
`endif

module pipeline_hazard_ctrl #(
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [6:0]                   id_opcode,
  input  logic [4:0]                   id_readAddr1,
  input  logic [4:0]                   id_readAddr2,
  input  logic [4:0]                   id_writeAddr,
  input  logic                         id_regWriteEnable,
  input  logic [`DataCacheControlBus]  id_dataCacheControl,
  input  logic                         ex_branchTaken,
  input  logic                         dc_ready,
  output logic                         dc_req,
  output logic                         pc_stall,
  output logic                         ifid_stall,
  output logic                         ifid_flush,
  output logic                         idex_bubble,
  output logic                         front_freeze,
  output logic                         memwb_bubble,
  output logic                         mem_timeout
);

  localparam logic [6:0] OP_RRR    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [3:0] WAIT_MAX  = 4'(MEM_WAIT_MAX);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  // Scoreboard. Only the fields each stage actually needs are kept:
  // EX needs the load flag for the forwarding case, and MEM needs the
  // cache-access flag.
  logic       ex_v_q, ex_v_d, ex_ld_q, ex_ld_d, ex_mem_q, ex_mem_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       mem_v_q, mem_v_d, mem_mem_q, mem_mem_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       wb_v_q, wb_v_d;
  logic [4:0] wb_rd_q, wb_rd_d;

  logic use_rs1, use_rs2;
  logic hit_ex, hit_mem, hit_wb;
  logic raw_stall, flush, id_issue;
  logic [3:0] wait_cnt_inc;

  function automatic logic src_hit(input logic v, input logic [4:0] rd,
                                   input logic u1, input logic u2,
                                   input logic [4:0] a1, input logic [4:0] a2);
    return v && (rd != 5'd0) && ((u1 && (a1 == rd)) || (u2 && (a2 == rd)));
  endfunction

  // RAW detection against the in-flight destinations. JAL reads no register.
  // Only R-type, stores and branches read rs2. The flush check sits here too
  // because it decides whether the ID instruction is allowed to issue.
  always_comb begin
    use_rs1   = (id_opcode != OP_JAL);
    use_rs2   = (id_opcode == OP_RRR) || (id_opcode == OP_STORE) ||
                (id_opcode == OP_BRANCH);
    hit_ex    = src_hit(ex_v_q, ex_rd_q, use_rs1, use_rs2, id_readAddr1, id_readAddr2);
    hit_mem   = src_hit(mem_v_q, mem_rd_q, use_rs1, use_rs2, id_readAddr1, id_readAddr2);
    hit_wb    = src_hit(wb_v_q, wb_rd_q, use_rs1, use_rs2, id_readAddr1, id_readAddr2);
    if (FWD_EN)
      raw_stall = id_valid && hit_ex && ex_ld_q;
    else
      raw_stall = id_valid && (hit_ex || hit_mem || hit_wb);
    flush     = ex_branchTaken && (state_q == RUN);
    id_issue  = id_valid && !raw_stall && !flush;
  end

  // FSM next-state plus all control outputs. In RUN the scoreboard shifts
  // unless the MEM access misses this cycle. In that case everything holds
  // so that the waiting instruction stays in MEM for the whole wait. In
  // MEM_WAIT the stall/flush logic of ID is ignored. The front end is simply
  // frozen, and a held EX branch is acted on again once back in RUN.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    ex_v_d       = ex_v_q;
    ex_rd_d      = ex_rd_q;
    ex_ld_d      = ex_ld_q;
    ex_mem_d     = ex_mem_q;
    mem_v_d      = mem_v_q;
    mem_rd_d     = mem_rd_q;
    mem_mem_d    = mem_mem_q;
    wb_v_d       = wb_v_q;
    wb_rd_d      = wb_rd_q;
    wait_cnt_inc = wait_cnt_q + 4'd1;
    dc_req       = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    front_freeze = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        dc_req     = mem_mem_q;
        wait_cnt_d = 4'd0;
        if (flush) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (raw_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
        if (mem_mem_q && !dc_ready) begin
          state_d = MEM_WAIT;
        end else begin
          wb_v_d    = mem_v_q;
          wb_rd_d   = mem_rd_q;
          mem_v_d   = ex_v_q;
          mem_rd_d  = ex_rd_q;
          mem_mem_d = ex_mem_q;
          ex_v_d    = id_issue && id_regWriteEnable && (id_writeAddr != 5'd0);
          ex_rd_d   = id_writeAddr;
          ex_ld_d   = id_issue && (id_dataCacheControl == `DataCacheRead);
          ex_mem_d  = id_issue && ((id_dataCacheControl == `DataCacheRead) ||
                                   (id_dataCacheControl == `DataCacheWrite));
        end
      end
      MEM_WAIT: begin
        dc_req       = 1'b1;
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        front_freeze = 1'b1;
        memwb_bubble = 1'b1;
        if (dc_ready) begin
          state_d    = RUN;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          // The counter saturates at the limit. The flag latches on the
          // cycle the count reaches it.
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == WAIT_MAX)
            timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, wait counter, timeout flag and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 4'd0;
      timeout_q  <= 1'b0;
      ex_v_q     <= 1'b0;
      ex_rd_q    <= 5'd0;
      ex_ld_q    <= 1'b0;
      ex_mem_q   <= 1'b0;
      mem_v_q    <= 1'b0;
      mem_rd_q   <= 5'd0;
      mem_mem_q  <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      ex_v_q     <= ex_v_d;
      ex_rd_q    <= ex_rd_d;
      ex_ld_q    <= ex_ld_d;
      ex_mem_q   <= ex_mem_d;
      mem_v_q    <= mem_v_d;
      mem_rd_q   <= mem_rd_d;
      mem_mem_q  <= mem_mem_d;
      wb_v_q     <= wb_v_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//
// Drives two copies of pipeline_hazard_ctrl from the same inputs. One copy
// has forwarding (FWD_EN=1) and the other has a full interlock (FWD_EN=0).
// Every cycle, each output vector is compared against a reference model.
// The model tracks the pending destinations as a small array of register
// numbers, with 0 meaning "nothing pending". A few scenario checks compare
// against hand-derived constants.

module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] DC_NOP    = 2'b00;
  localparam logic [1:0] DC_READ   = 2'b01;
  localparam logic [1:0] DC_WRITE  = 2'b10;
  localparam int         WAIT_MAX  = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_wen;
  logic [1:0] id_dcc;
  logic       ex_br;
  logic       dc_ready;

  logic dc_req [2], pc_stall [2], ifid_stall [2], ifid_flush [2];
  logic idex_bubble [2], front_freeze [2], memwb_bubble [2], mem_timeout [2];
  logic [7:0] obs_vec [2];

  int checks = 0;
  int errors = 0;

  // Reference state per instance m (index = FWD_EN value).
  // Slot 0 = EX, 1 = MEM, 2 = WB. A register number of 0 means no pending write.
  logic [4:0] sb_rd  [2][3];
  logic       sb_ld  [2][3];
  logic       sb_mem [2][3];
  logic       waiting [2];
  int         waited [2];
  logic       timed_out [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FWD_EN(1'b0), .MEM_WAIT_MAX(WAIT_MAX)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_readAddr1(id_rs1), .id_readAddr2(id_rs2), .id_writeAddr(id_rd),
    .id_regWriteEnable(id_wen), .id_dataCacheControl(id_dcc),
    .ex_branchTaken(ex_br), .dc_ready(dc_ready), .dc_req(dc_req[0]),
    .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]), .ifid_flush(ifid_flush[0]),
    .idex_bubble(idex_bubble[0]), .front_freeze(front_freeze[0]),
    .memwb_bubble(memwb_bubble[0]), .mem_timeout(mem_timeout[0]));

  pipeline_hazard_ctrl #(.FWD_EN(1'b1), .MEM_WAIT_MAX(WAIT_MAX)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_readAddr1(id_rs1), .id_readAddr2(id_rs2), .id_writeAddr(id_rd),
    .id_regWriteEnable(id_wen), .id_dataCacheControl(id_dcc),
    .ex_branchTaken(ex_br), .dc_ready(dc_ready), .dc_req(dc_req[1]),
    .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]), .ifid_flush(ifid_flush[1]),
    .idex_bubble(idex_bubble[1]), .front_freeze(front_freeze[1]),
    .memwb_bubble(memwb_bubble[1]), .mem_timeout(mem_timeout[1]));

  assign obs_vec[0] = {dc_req[0], pc_stall[0], ifid_stall[0], ifid_flush[0],
                       idex_bubble[0], front_freeze[0], memwb_bubble[0], mem_timeout[0]};
  assign obs_vec[1] = {dc_req[1], pc_stall[1], ifid_stall[1], ifid_flush[1],
                       idex_bubble[1], front_freeze[1], memwb_bubble[1], mem_timeout[1]};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic srcHit(input logic [4:0] rd);
    logic reads1, reads2;
    reads1 = (id_opcode != OP_JAL);
    reads2 = (id_opcode == OP_R) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
    return (rd != 5'd0) && ((reads1 && id_rs1 == rd) || (reads2 && id_rs2 == rd));
  endfunction

  function automatic logic modelStall(input int m);
    if (!id_valid) return 1'b0;
    if (m == 1) return sb_ld[1][0] && srcHit(sb_rd[1][0]);
    return srcHit(sb_rd[0][0]) || srcHit(sb_rd[0][1]) || srcHit(sb_rd[0][2]);
  endfunction

  // Expected {dc_req, pc_stall, ifid_stall, ifid_flush, idex_bubble,
  //           front_freeze, memwb_bubble, mem_timeout}.
  function automatic logic [7:0] modelExpect(input int m);
    logic [7:0] e;
    e = 8'h00;
    if (waiting[m]) begin
      e = 8'b1110_0110;
    end else begin
      e[7] = sb_mem[m][1];
      if (ex_br) begin
        e[4] = 1'b1;
        e[3] = 1'b1;
      end else if (modelStall(m)) begin
        e[6] = 1'b1;
        e[5] = 1'b1;
        e[3] = 1'b1;
      end
    end
    e[0] = timed_out[m];
    return e;
  endfunction

  task automatic modelClock();
    logic issue;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          sb_rd[m][k] = 5'd0; sb_ld[m][k] = 1'b0; sb_mem[m][k] = 1'b0;
        end
        waiting[m] = 1'b0; waited[m] = 0; timed_out[m] = 1'b0;
      end else if (waiting[m]) begin
        if (dc_ready) begin
          waiting[m] = 1'b0;
          waited[m]  = 0;
        end else begin
          waited[m] = waited[m] + 1;
          if (waited[m] >= WAIT_MAX) timed_out[m] = 1'b1;
        end
      end else if (sb_mem[m][1] && !dc_ready) begin
        waiting[m] = 1'b1;
        waited[m]  = 0;
      end else begin
        issue = id_valid && !ex_br && !modelStall(m);
        for (int k = 2; k > 0; k--) begin
          sb_rd[m][k] = sb_rd[m][k-1]; sb_ld[m][k] = sb_ld[m][k-1]; sb_mem[m][k] = sb_mem[m][k-1];
        end
        sb_rd[m][0]  = (issue && id_wen) ? id_rd : 5'd0;
        sb_ld[m][0]  = issue && (id_dcc == DC_READ);
        sb_mem[m][0] = issue && (id_dcc == DC_READ || id_dcc == DC_WRITE);
      end
    end
  endtask

  // Drive one cycle's inputs, then at the falling edge compare both copies
  // against the model.
  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] wd, input logic wen,
                               input logic [1:0] dcc, input logic br, input logic rdy,
                               input logic rs);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = wd;
    id_wen = wen; id_dcc = dcc; ex_br = br; dc_ready = rdy; rst = rs;
    #4;
    for (int m = 0; m < 2; m++)
      checkOutput($sformatf("model_fwd%0d", m), {24'd0, obs_vec[m]}, {24'd0, modelExpect(m)});
  endtask

  task automatic tick();
    modelClock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls, freezes, first_to;
    logic [6:0] ops [8];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};

    id_valid = 1'b0; id_opcode = OP_I; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_wen = 1'b0; id_dcc = DC_NOP; ex_br = 1'b0; dc_ready = 1'b1; rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) begin
        sb_rd[m][k] = 5'd0; sb_ld[m][k] = 1'b0; sb_mem[m][k] = 1'b0;
      end
      waiting[m] = 1'b0; waited[m] = 0; timed_out[m] = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state: every output low.
    applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_outs_fwd0", {24'd0, obs_vec[0]}, 32'd0);
    checkOutput("reset_outs_fwd1", {24'd0, obs_vec[1]}, 32'd0);
    tick();

    // lw x5 then add x6,x5,x1. The forwarding copy stalls exactly one cycle.
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, DC_READ, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_load_use_stall", {31'd0, pc_stall[1] & idex_bubble[1]}, 32'd1);
    tick();
    applyStimulus(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_add_issues", {31'd0, pc_stall[1]}, 32'd0);
    tick();
    idle(4);

    // addi x3 then sw x3. The interlocked copy stalls while x3 is in EX, MEM and WB.
    applyStimulus(1'b1, OP_I, 5'd1, 5'd0, 5'd3, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    tick();
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, OP_STORE, 5'd2, 5'd3, 5'd0, 1'b0, DC_WRITE, 1'b0, 1'b1, 1'b0);
      if (!pc_stall[0]) begin
        tick();
        break;
      end
      stalls++;
      tick();
    end
    checkOutput("t2_interlock_stalls", stalls, 32'd3);
    idle(4);
    applyStimulus(1'b1, OP_I, 5'd1, 5'd0, 5'd0, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, OP_STORE, 5'd0, 5'd0, 5'd0, 1'b0, DC_WRITE, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_x0_no_stall", {31'd0, pc_stall[0]}, 32'd0);
    tick();
    idle(4);

    // lw whose cache access is not ready for 4 cycles. The first cycle issues the
    // request, and the next 4 are MEM_WAIT cycles with the front end frozen.
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b1, DC_READ, 1'b0, 1'b1, 1'b0);
    tick();
    idle(1);
    freezes = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, (i >= 4), 1'b0);
      if (front_freeze[0] && memwb_bubble[0]) freezes++;
      tick();
    end
    checkOutput("t3_wait_cycles", freezes, 32'd4);
    checkOutput("t3_no_timeout", {31'd0, mem_timeout[0]}, 32'd0);
    idle(3);

    // A branch in EX during a load-use stall. The flush wins and the flushed add
    // (rd=x8) must not appear as a pending write.
    applyStimulus(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd4, 1'b1, DC_READ, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, OP_R, 5'd4, 5'd0, 5'd8, 1'b1, DC_NOP, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_flush", {30'd0, ifid_flush[1], pc_stall[1]}, 32'b10);
    tick();
    applyStimulus(1'b1, OP_I, 5'd8, 5'd0, 5'd9, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_flushed_slot_empty", {31'd0, pc_stall[0]}, 32'd0);
    tick();
    idle(4);

    // JAL ignores rs1, so a pending x10 does not stall it.
    applyStimulus(1'b1, OP_I, 5'd1, 5'd0, 5'd10, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, OP_JAL, 5'd10, 5'd10, 5'd1, 1'b1, DC_NOP, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_jal_no_stall", {31'd0, pc_stall[0]}, 32'd0);
    tick();
    idle(4);

    // Cache never answers. The flag appears once 15 full wait cycles have
    // elapsed, which is wait cycle 16 counting the request cycle as 0.
    // A reset then clears everything.
    applyStimulus(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b1, DC_READ, 1'b0, 1'b1, 1'b0);
    tick();
    idle(1);
    first_to = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, 1'b0, 1'b0);
      if (mem_timeout[0] && first_to < 0) first_to = i;
      tick();
    end
    checkOutput("t5_timeout_cycle", first_to, 32'd16);
    applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, DC_NOP, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_after_reset_fwd0", {24'd0, obs_vec[0]}, 32'd0);
    checkOutput("t5_after_reset_fwd1", {24'd0, obs_vec[1]}, 32'd0);
    tick();

    // Random traffic over a small register range so that hazards are frequent.
    for (int n = 0; n < 800; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      applyStimulus(($urandom_range(0, 9) != 0), op,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
